// File: rtl/conva1_ctrl_pkg.sv
// Shared types and derived-size helpers for the conv layer 1 controller.
package conva1_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD_W,
      ST_STREAM,
      ST_DRAIN,
      ST_DONE
   } state_t;

   function automatic int ifm_size_next(input int ifm_size, input int kernal_size);
      return ifm_size - kernal_size + 1;
   endfunction

   // Address width for n entries, never narrower than one bit.
   function automatic int addr_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/conva1_ctrl_delay.sv
// Fixed-depth shift register with async clear; aligns strobes and their side data.
module conva1_ctrl_delay #(
   parameter int DEPTH = 1,
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] stage [DEPTH];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int unsigned i = 0; i < DEPTH; i++) stage[i] <= '0;
      end else begin
         stage[0] <= d;
         for (int unsigned i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
      end
   end

   assign q = stage[DEPTH-1];

endmodule

// File: rtl/conva1_controller.sv
// Per-filter weight load / IFM stream sequencer for conv layer 1.
// Optional `perf_cycles` busy-cycle counter when CONVA1_CTRL_PERF_EN is defined.
module conva1_controller
   import conva1_ctrl_pkg::*;
#(
   parameter int IFM_SIZE          = 32,
   parameter int KERNAL_SIZE       = 5,
   parameter int NUMBER_OF_FILTERS = 6,
   parameter int CONV_LATENCY      = 3,
   localparam int IFM_SIZE_NEXT         = ifm_size_next(IFM_SIZE, KERNAL_SIZE),
   localparam int ADDRESS_SIZE_IFM      = addr_w(IFM_SIZE * IFM_SIZE),
   localparam int ADDRESS_SIZE_NEXT_IFM = addr_w(IFM_SIZE_NEXT * IFM_SIZE_NEXT),
   localparam int ADDRESS_SIZE_WM       = addr_w(KERNAL_SIZE * KERNAL_SIZE * NUMBER_OF_FILTERS),
   localparam int SEL_W                 = addr_w(NUMBER_OF_FILTERS)
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic                             start,
   output logic                             busy,
   output logic                             done,
   output logic                             wm_enable_read,
   output logic [ADDRESS_SIZE_WM-1:0]       wm_address,
   output logic                             wm_fifo_enable,
   output logic                             ifm_read_enable,
   output logic [ADDRESS_SIZE_IFM-1:0]      ifm_address,
   output logic                             fifo_enable,
   output logic                             conv_enable,
   output logic                             ofm_write_enable,
   output logic [ADDRESS_SIZE_NEXT_IFM-1:0] ofm_address,
   output logic [SEL_W-1:0]                 ofm_select
`ifdef CONVA1_CTRL_PERF_EN
   ,
   output logic [31:0]                      perf_cycles
`endif
);

   localparam int CNT_W = ADDRESS_SIZE_IFM + 1;
   localparam int POS_W = addr_w(IFM_SIZE);

   localparam logic [CNT_W-1:0]           LOAD_LAST   = CNT_W'(KERNAL_SIZE * KERNAL_SIZE - 1);
   localparam logic [CNT_W-1:0]           STREAM_LAST = CNT_W'(IFM_SIZE * IFM_SIZE - 1);
   localparam logic [CNT_W-1:0]           DRAIN_LAST  = CNT_W'(1 + CONV_LATENCY);
   localparam logic [POS_W-1:0]           POS_LAST    = POS_W'(IFM_SIZE - 1);
   localparam logic [POS_W-1:0]           WIN_FIRST   = POS_W'(KERNAL_SIZE - 1);
   localparam logic [SEL_W-1:0]           F_LAST      = SEL_W'(NUMBER_OF_FILTERS - 1);
   localparam logic [ADDRESS_SIZE_WM-1:0] K2          = ADDRESS_SIZE_WM'(KERNAL_SIZE * KERNAL_SIZE);

   state_t                           state, next_state;
   logic [CNT_W-1:0]                 cnt;
   logic [POS_W-1:0]                 row, col;
   logic [SEL_W-1:0]                 f;
   logic [ADDRESS_SIZE_WM-1:0]       wm_base;
   logic [ADDRESS_SIZE_NEXT_IFM-1:0] conv_addr;
   logic                             window_valid;

   always_comb begin
      next_state      = state;
      busy            = 1'b0;
      done            = 1'b0;
      wm_enable_read  = 1'b0;
      wm_address      = '0;
      ifm_read_enable = 1'b0;
      ifm_address     = '0;
      window_valid    = 1'b0;
      case (state)
         ST_IDLE: if (start) next_state = ST_LOAD_W;
         ST_LOAD_W: begin
            busy           = 1'b1;
            wm_enable_read = 1'b1;
            wm_address     = wm_base + ADDRESS_SIZE_WM'(cnt);
            if (cnt == LOAD_LAST) next_state = ST_STREAM;
         end
         ST_STREAM: begin
            busy            = 1'b1;
            ifm_read_enable = 1'b1;
            ifm_address     = ADDRESS_SIZE_IFM'(cnt);
            window_valid    = (row >= WIN_FIRST) && (col >= WIN_FIRST);
            if (cnt == STREAM_LAST) next_state = ST_DRAIN;
         end
         ST_DRAIN: begin
            busy = 1'b1;
            if (cnt == DRAIN_LAST) next_state = (f == F_LAST) ? ST_DONE : ST_LOAD_W;
         end
         ST_DONE: begin
            done       = 1'b1;
            next_state = ST_IDLE;
         end
         default: next_state = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= ST_IDLE;
         cnt       <= '0;
         row       <= '0;
         col       <= '0;
         f         <= '0;
         wm_base   <= '0;
         conv_addr <= '0;
      end else begin
         state <= next_state;
         // Phase counter restarts on every state change, including DRAIN -> LOAD_W.
         if (next_state != state || state == ST_IDLE) cnt <= '0;
         else cnt <= cnt + CNT_W'(1);

         if (state == ST_STREAM) begin
            if (col == POS_LAST) begin
               col <= '0;
               row <= row + POS_W'(1);
            end else begin
               col <= col + POS_W'(1);
            end
         end else begin
            row <= '0;
            col <= '0;
         end

         if (state == ST_IDLE && start) begin
            f       <= '0;
            wm_base <= '0;
         end else if (state == ST_DRAIN && next_state == ST_LOAD_W) begin
            f       <= f + SEL_W'(1);
            wm_base <= wm_base + K2;
         end

         if (state == ST_LOAD_W) conv_addr <= '0;
         else if (conv_enable) conv_addr <= conv_addr + ADDRESS_SIZE_NEXT_IFM'(1);
      end
   end

   conva1_ctrl_delay #(.DEPTH(1), .WIDTH(2)) u_mem_align (
      .clk   (clk),
      .reset (reset),
      .d     ({wm_enable_read, ifm_read_enable}),
      .q     ({wm_fifo_enable, fifo_enable})
   );

   // Read cycle -> FIFO shift -> convolve: validity trails the read by two cycles.
   conva1_ctrl_delay #(.DEPTH(2), .WIDTH(1)) u_window (
      .clk   (clk),
      .reset (reset),
      .d     (window_valid),
      .q     (conv_enable)
   );

   conva1_ctrl_delay #(.DEPTH(CONV_LATENCY), .WIDTH(1 + ADDRESS_SIZE_NEXT_IFM + SEL_W)) u_write (
      .clk   (clk),
      .reset (reset),
      .d     ({conv_enable, conv_addr, f}),
      .q     ({ofm_write_enable, ofm_address, ofm_select})
   );

`ifdef CONVA1_CTRL_PERF_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) perf_cycles <= '0;
      else if (state == ST_IDLE && start) perf_cycles <= '0;
      else if (busy) perf_cycles <= perf_cycles + 32'd1;
   end
`else
   // Build without the busy-cycle counter.
`endif

endmodule

// File: tb/tb_conva1_controller.sv
// Directed bench for conva1_controller at IFM=6, K=3, two filters, latency 2.
module tb_conva1_controller;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       start = 1'b0;
   logic       busy, done;
   logic       wm_enable_read, wm_fifo_enable;
   logic [4:0] wm_address;
   logic       ifm_read_enable, fifo_enable;
   logic [5:0] ifm_address;
   logic       conv_enable, ofm_write_enable;
   logic [3:0] ofm_address;
   logic [0:0] ofm_select;
`ifdef CONVA1_CTRL_PERF_EN
   logic [31:0] perf_cycles;
`endif

   int tests_run = 0;
   int tests_failed = 0;

   always #5 clk = ~clk;

   conva1_controller #(
      .IFM_SIZE          (6),
      .KERNAL_SIZE       (3),
      .NUMBER_OF_FILTERS (2),
      .CONV_LATENCY      (2)
   ) dut (
      .clk              (clk),
      .reset            (reset),
      .start            (start),
      .busy             (busy),
      .done             (done),
      .wm_enable_read   (wm_enable_read),
      .wm_address       (wm_address),
      .wm_fifo_enable   (wm_fifo_enable),
      .ifm_read_enable  (ifm_read_enable),
      .ifm_address      (ifm_address),
      .fifo_enable      (fifo_enable),
      .conv_enable      (conv_enable),
      .ofm_write_enable (ofm_write_enable),
      .ofm_address      (ofm_address),
      .ofm_select       (ofm_select)
`ifdef CONVA1_CTRL_PERF_EN
      ,
      .perf_cycles      (perf_cycles)
`endif
   );

   typedef struct {
      int busy, done, wre, wfe, ire, fe, ce, owe;
      int wa, ia, oa, os;
   } exp_t;

   task automatic check(input string tag, input int got, input int want);
      tests_run++;
      if (got !== want) begin
         tests_failed++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, want, $time);
      end
   endtask

   function automatic int win_ok(input int p);
      return (p >= 0 && p < 36 && p / 6 >= 2 && p % 6 >= 2) ? 1 : 0;
   endfunction

   // n = cycles after the posedge that accepted start; 49 cycles per filter.
   function automatic exp_t model(input int n);
      exp_t e;
      int f, t, p;
      e = '{default: 0};
      if (n == 98) e.done = 1;
      if (n < 0 || n >= 98) return e;
      f = n / 49;
      t = n % 49;
      e.busy = 1;
      e.wre  = (t < 9) ? 1 : 0;
      e.wa   = f * 9 + t;
      e.wfe  = (t >= 1 && t <= 9) ? 1 : 0;
      e.ire  = (t >= 9 && t < 45) ? 1 : 0;
      e.ia   = t - 9;
      e.fe   = (t >= 10 && t <= 45) ? 1 : 0;
      e.ce   = win_ok(t - 11);
      p      = t - 13;
      e.owe  = win_ok(p);
      if (e.owe != 0) begin
         e.oa = (p / 6 - 2) * 4 + (p % 6 - 2);
         e.os = f;
      end
      return e;
   endfunction

   task automatic check_all_zero(input string pre);
      check({pre, "_busy"}, busy, 0);
      check({pre, "_done"}, done, 0);
      check({pre, "_wre"}, wm_enable_read, 0);
      check({pre, "_wa"}, wm_address, 0);
      check({pre, "_wfe"}, wm_fifo_enable, 0);
      check({pre, "_ire"}, ifm_read_enable, 0);
      check({pre, "_ia"}, ifm_address, 0);
      check({pre, "_fe"}, fifo_enable, 0);
      check({pre, "_ce"}, conv_enable, 0);
      check({pre, "_owe"}, ofm_write_enable, 0);
      check({pre, "_oa"}, ofm_address, 0);
      check({pre, "_os"}, ofm_select, 0);
`ifdef CONVA1_CTRL_PERF_EN
      check({pre, "_perf"}, perf_cycles, 0);
`endif
   endtask

   task automatic pulse_start();
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
   endtask

   // Full run with optional ignored start at glitch_n, or a reset at reset_n.
   task automatic run(input int glitch_n, input int reset_n);
      exp_t e;
      int writes, dones, first_w, last_w;
      writes = 0; dones = 0; first_w = -1; last_w = -1;
      pulse_start();
      for (int n = 0; n < 120; n++) begin
         @(negedge clk);
         if (n == reset_n) begin
            reset = 1'b1;
            #1;
            check_all_zero("rst_mid");
            @(posedge clk); #1 reset = 1'b0;
            for (int k = 0; k < 60; k++) begin
               @(negedge clk);
               check("post_rst_owe", ofm_write_enable, 0);
               check("post_rst_busy", busy, 0);
               check("post_rst_ce", conv_enable, 0);
            end
            return;
         end
         e = model(n);
         check("busy", busy, e.busy);
         check("done", done, e.done);
         check("wm_enable_read", wm_enable_read, e.wre);
         check("wm_fifo_enable", wm_fifo_enable, e.wfe);
         check("ifm_read_enable", ifm_read_enable, e.ire);
         check("fifo_enable", fifo_enable, e.fe);
         check("conv_enable", conv_enable, e.ce);
         check("ofm_write_enable", ofm_write_enable, e.owe);
         if (e.wre != 0) check("wm_address", wm_address, e.wa);
         if (e.ire != 0) check("ifm_address", ifm_address, e.ia);
         if (e.owe != 0) begin
            check("ofm_address", ofm_address, e.oa);
            check("ofm_select", ofm_select, e.os);
         end
         if (ofm_write_enable) begin
            writes++;
            if (first_w < 0) first_w = n;
            last_w = n;
         end
         if (done) dones++;
`ifdef CONVA1_CTRL_PERF_EN
         if (n == 99) check("perf_after_done", perf_cycles, 98);
         if (n == 119) check("perf_hold_idle", perf_cycles, 98);
`endif
         start = (n == glitch_n) ? 1'b1 : 1'b0;
      end
      check("write_count", writes, 32);
      check("done_count", dones, 1);
      check("first_write_n", first_w, 27);
      check("last_write_n", last_w, 97);
   endtask

   initial begin
      #2;
      check_all_zero("rst");
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      check_all_zero("idle");

      run(-1, -1);
      run(19, -1);
      run(-1, 29);
      run(-1, -1);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/conva1_controller.md
# conva1_controller

Sequencer for the first convolution layer's compute units. On a `start` pulse it runs every filter in turn: loads that filter's K×K weights from each unit's weight memory into the unit's weight FIFO, then streams the full input feature map through the units' IFM FIFOs. It asserts `conv_enable` only on valid windows and emits output-feature-map write strobes and addresses. All NUMBER_OF_UNITS units receive the same control broadcast; the controller sits between the layer top and the unit array.

## Interface
- IFM_SIZE, 32, input feature map side length
- KERNAL_SIZE, 5, kernel side length
- NUMBER_OF_FILTERS, 6, filters processed per run
- CONV_LATENCY, 3, cycles from `conv_enable` to valid `unit_data_out`
- Derived constants: IFM_SIZE_NEXT = IFM_SIZE−KERNAL_SIZE+1; ADDRESS_SIZE_IFM = $clog2(IFM_SIZE²); ADDRESS_SIZE_NEXT_IFM = $clog2(IFM_SIZE_NEXT²); ADDRESS_SIZE_WM = $clog2(K²·NUMBER_OF_FILTERS)

Ports:
- clk  in  1  single clock; all logic rises on posedge
- reset  in  1  asynchronous, active-high; clears all state
- start  in  1  single-cycle run request; accepted only in IDLE
- busy  out  1  high from the cycle after accepted start until done
- done  out  1  one-cycle pulse after the last OFM write
- wm_enable_read  out  1  weight memory read strobe
- wm_address  out  ADDRESS_SIZE_WM  weight memory address
- wm_fifo_enable  out  1  weight FIFO shift
- ifm_read_enable  out  1  IFM memory read strobe
- ifm_address  out  ADDRESS_SIZE_IFM  IFM memory address
- fifo_enable  out  1  IFM FIFO shift
- conv_enable  out  1  convolution enable
- ofm_write_enable  out  1  OFM write strobe
- ofm_address  out  ADDRESS_SIZE_NEXT_IFM  OFM write address
- ofm_select  out  $clog2(NUMBER_OF_FILTERS)  filter index of the current OFM write

## Operation
- States: IDLE → LOAD_W → STREAM → DRAIN → (LOAD_W for the next filter | DONE) → IDLE.
- IDLE: all strobes 0. On `start`, clear filter counter f to 0 and go to LOAD_W.
- LOAD_W: K² cycles with `wm_enable_read`=1 and `wm_address` = f·K² + k, for k = 0…K²−1. Then go to STREAM.
- STREAM: IFM_SIZE² cycles with `ifm_read_enable`=1 and `ifm_address` = p, for p = 0…IFM_SIZE²−1, in row-major order. Then go to DRAIN.
- DRAIN: wait until the last OFM write of filter f has issued. Then, if f < NUMBER_OF_FILTERS−1, increment f and go to LOAD_W; otherwise go to DONE.
- DONE: hold for one cycle with `done`=1, then go to IDLE.
- Memories have 1-cycle read latency, so `wm_fifo_enable` = `wm_enable_read` delayed 1 and `fifo_enable` = `ifm_read_enable` delayed 1.
- Window validity: pixel p has row r = p / IFM_SIZE and column c = p mod IFM_SIZE. `conv_enable` is asserted the cycle after p is shifted in, only when r ≥ K−1 and c ≥ K−1.
- `ofm_write_enable` = `conv_enable` delayed CONV_LATENCY.
- `ofm_address` is 0 at the start of each filter and increments after every write, reaching IFM_SIZE_NEXT²−1.
- `ofm_select` is f, carried through the delay line so it stays aligned with `ofm_write_enable`.
- No FIFO flush between filters: stale FIFO contents never reach an enabled window, because validity requires K−1 fresh rows.
- `start` while busy is ignored.
- Reset mid-run: the controller returns to IDLE immediately and all delay lines are cleared, so no late strobes appear afterwards.

## Timing
- Every output resets to 0.
- Let S be the first STREAM cycle. Pixel p is read at S+p, shifted in at S+p+1, convolved at S+p+2 (if valid) and written at S+p+2+CONV_LATENCY.
- DRAIN lasts 2+CONV_LATENCY cycles.
- Cycles per filter: K² + IFM_SIZE² + 2 + CONV_LATENCY.
- The final `wm_fifo_enable` beat overlaps the first STREAM cycle. This is legal because the two strobes drive separate FIFOs.

## Configuration
- CONVA1_CTRL_PERF_EN defined:
  - Adds output `perf_cycles` (32 bits). It clears on accepted start, increments every cycle while `busy`=1, holds after done and resets to 0.
- CONVA1_CTRL_PERF_EN undefined: the port and the counter are absent.

## Structure
- Package `conva1_ctrl_pkg` holds the state enum and the derived-constant functions (IFM_SIZE_NEXT, address widths).
- Sub-module `conva1_ctrl_delay`: a parameterized-depth, parameterized-width shift register with async reset. It is used for the 1-cycle memory alignment and for the CONV_LATENCY write path (write enable, address and `ofm_select` together).

## Test plan
Bench configuration: IFM_SIZE=6, K=3, filters=2, CONV_LATENCY=2.
- Single start: `wm_address` runs 0–8, then later 9–17. Each filter produces exactly 16 `ofm_write_enable` pulses with addresses 0–15. The first write is at S+18, the last at S+39. `done` pulses once; total run is 2·(9+36+4)=98 busy cycles.
- Window gating: `conv_enable` is never high for pixels with c<2 or r<2. It is high for p = 14,15,16,17,20,…,35.
- Alignment: `wm_fifo_enable` and `fifo_enable` each equal their read strobe shifted by exactly 1 cycle. `ofm_select` reads 0 for the first 16 writes and 1 for the next 16.
- `start` re-asserted at S+10: ignored, with no change to any counter or address.
- Reset asserted at S+20: all outputs 0 in that cycle and no writes afterwards. A new start then repeats the first scenario exactly.
- With CONVA1_CTRL_PERF_EN: `perf_cycles` reads 98 after done and holds through 20 idle cycles.
